// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: opcodes, fetch FSM states and fetch-queue entries.
package rv32i_types;

  // Conditional-branch major opcode.
  localparam logic [6:0] op_br = 7'b1100011;

  // Fetch controller states.
  typedef enum logic [1:0] {
    REQ     = 2'd0,
    IDLE    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // One buffered fetch result handed to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO between fetch and decode, with a single-cycle flush.
// The occupancy count runs 0..DEPTH so full and empty are distinct.
module fetch_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output fq_entry_t     head_data
);

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  // Flush dominates: a flushing cycle neither stores nor retires an entry.
  assign push_ok = push & ~flush;
  assign pop_ok  = pop & ~flush;

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + AW'(1);
      if (pop_ok)  head_d = head_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless while the slot is not counted.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= push_data;
  end

  assign count     = count_q;
  assign head_data = mem_q[head_q];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage front end: owns the fetch PC, keeps at most one instruction
// memory request outstanding, consults the predictor on each returned word and
// buffers results for decode. Execute redirects flush the queue; a response
// still in flight when a redirect arrives is waited out and thrown away.
//
// Handshake: imem_read is held with a stable imem_addr until the one-cycle
// imem_resp strobe; decode takes the queue head in any cycle where fq_valid
// and fq_ready are both high and no redirect is present.
module fetch_pc_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fq_valid,
  output logic [31:0] fq_pc,
  output logic [31:0] fq_instr,
  output logic        fq_pred_taken,
  input  logic        fq_ready
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [CW-1:0] fq_count;
  fq_entry_t     push_entry;
  fq_entry_t     head_entry;
  logic          push;
  logic          pop;
  logic [CW:0]   occ_after_push;
  logic [CW:0]   occ_after_pop;

  assign imem_read   = ((state_q == REQ) || (state_q == DISCARD)) && !rst;
  assign imem_addr   = pc_q;
  assign fetch_valid = (state_q == REQ) && imem_resp && !redirect;
  assign fetch_pc    = pc_q;
  assign fetch_instr = imem_rdata;

  assign fq_valid = (fq_count != '0);
  assign pop      = fq_valid && fq_ready && !redirect;
  assign push     = fetch_valid;

  // Only conditional branches carry a taken prediction into decode.
  assign push_entry = '{pc:         pc_q,
                        instr:      imem_rdata,
                        pred_taken: pred_taken && (imem_rdata[6:0] == op_br)};

  // Occupancy seen by the next cycle, used to decide whether a new request fits.
  assign occ_after_push = {1'b0, fq_count} + (CW+1)'(1) - (CW+1)'(pop);
  assign occ_after_pop  = {1'b0, fq_count} - (CW+1)'(pop);

  // Next-state, PC and pending-redirect selection.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      REQ: begin
        if (imem_resp && redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (imem_resp) begin
          pc_d    = pred_target;
          state_d = (occ_after_push < (CW+1)'(FQ_DEPTH)) ? REQ : IDLE;
        end else if (redirect) begin
          pend_pc_d = redirect_pc;
          state_d   = DISCARD;
        end
      end
      IDLE: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (occ_after_pop < (CW+1)'(FQ_DEPTH)) begin
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (imem_resp) begin
          pc_d    = redirect ? redirect_pc : pend_pc_q;
          state_d = REQ;
        end else if (redirect) begin
          pend_pc_d = redirect_pc;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // FSM and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_fetch_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect),
    .count    (fq_count),
    .head_data(head_entry)
  );

  assign fq_pc         = head_entry.pc;
  assign fq_instr      = head_entry.instr;
  assign fq_pred_taken = head_entry.pred_taken;

endmodule
